uart_cmd_framer: RTL

Assembles the serial command bytes from uart_byte_rx into one 88-bit sweep/PLL command word for frequency_sweeper.
- Replaces the generic byte FIFO between the UART receiver and the sweeper.
- Adds frame-level checks: inter-byte timeout, mode validation and overflow detection.
- Presents each complete, validated command through a single-entry valid/ready output register.

---
 rtl/uart_cmd_pkg.sv | 24 ++
 rtl/uart_cmd_timeout.sv | 33 +++
 rtl/uart_cmd_framer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command framer and its consumers.
// The frame layout matches the field order expected by frequency_sweeper.
package uart_cmd_pkg;

    localparam int FRAME_BYTES_DEF = 11;
    localparam int CMD_W           = 88;

    localparam logic [7:0] MODE_SWEEP = 8'h00;
    localparam logic [7:0] MODE_PLL   = 8'h01;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2
    } framer_state_t;

    typedef struct packed {
        logic [7:0]  mode;
        logic [31:0] init_freq;
        logic [15:0] cycles_per_step;
        logic [31:0] freq_step;
    } cmd_t;

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timer: cleared on each byte, counts while enabled, saturates at
// all-ones and strobes expired in the cycle it sits at LIMIT-1.
module uart_cmd_timeout #(
    parameter int LIMIT = 10000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int         W    = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);
    localparam logic [W-1:0] SAT  = '1;

    logic [W-1:0] count;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && count != SAT) begin
            count <= count + 1'b1;
        end
    end

    // A byte in the expiry cycle clears the timer, so it must also mask the strobe.
    assign expired = en && !clear && (count == LAST);

endmodule

// File: rtl/uart_cmd_framer.sv
// Collects UART bytes into one 88-bit command, validates it and holds it in a
// single-entry valid/ready register. `define CMD_CHECKSUM_EN adds a trailing XOR byte.
module uart_cmd_framer
    import uart_cmd_pkg::*;
#(
    parameter int         CLK_FREQ       = 50_000_000,
    parameter int         FRAME_BYTES    = FRAME_BYTES_DEF,
    parameter int         TIMEOUT_CYCLES = CLK_FREQ / 5000,
    parameter logic [7:0] MAX_MODE       = MODE_PLL
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       rx_byte,
    input  logic             rx_valid,
    output logic [CMD_W-1:0] cmd_data,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic             busy,
    output logic             timeout_err,
    output logic             mode_err,
    output logic             overflow_err
`ifdef CMD_CHECKSUM_EN
    ,
    output logic             chk_err
`endif
);

`ifdef CMD_CHECKSUM_EN
    localparam int TOTAL = FRAME_BYTES + 1;
`else
    localparam int TOTAL = FRAME_BYTES;
`endif
    localparam int CW = $clog2(TOTAL + 1);

    framer_state_t    state, next_state;
    logic [CW-1:0]    byte_cnt;
    logic [CMD_W-1:0] sbuf;
    logic             skid_valid;
    logic [7:0]       skid_byte;
    logic             in_valid, take, last_slot, expired, chk_bad;
    logic [7:0]       in_byte;
    logic             mode_pulse, ovf_pulse, load;
    cmd_t             frame;

    // A byte caught during CHECK is replayed first, ahead of the live input.
    assign in_valid  = skid_valid || rx_valid;
    assign in_byte   = skid_valid ? skid_byte : rx_byte;
    assign take      = in_valid && (state != CHECK);
    assign last_slot = (byte_cnt == CW'(TOTAL - 1));
    assign busy      = (byte_cnt != '0);
    assign frame     = cmd_t'(sbuf);

    uart_cmd_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (take || state != COLLECT),
        .en      (state == COLLECT),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        next_state = state;
        mode_pulse = 1'b0;
        ovf_pulse  = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE, COLLECT: begin
                if (in_valid)     next_state = last_slot ? CHECK : COLLECT;
                else if (expired) next_state = IDLE;
            end
            CHECK: begin
                next_state = IDLE;
                if (!chk_bad) begin
                    if (frame.mode > MAX_MODE)         mode_pulse = 1'b1;
                    else if (cmd_valid && !cmd_ready)  ovf_pulse  = 1'b1;
                    else                               load       = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt     <= '0;
            sbuf         <= '0;
            skid_valid   <= 1'b0;
            skid_byte    <= '0;
            cmd_data     <= '0;
            cmd_valid    <= 1'b0;
            timeout_err  <= 1'b0;
            mode_err     <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            timeout_err  <= expired;
            mode_err     <= mode_pulse;
            overflow_err <= ovf_pulse;

            if (take) begin
                byte_cnt <= byte_cnt + 1'b1;
                if (byte_cnt < CW'(FRAME_BYTES)) sbuf <= {in_byte, sbuf[CMD_W-1:8]};
            end else if (expired || state == CHECK) begin
                byte_cnt <= '0;
            end

            if (state == CHECK) begin
                if (rx_valid) begin
                    skid_valid <= 1'b1;
                    skid_byte  <= rx_byte;
                end
            end else if (skid_valid) begin
                skid_valid <= rx_valid;
                skid_byte  <= rx_byte;
            end

            if (load) begin
                cmd_data  <= sbuf;
                cmd_valid <= 1'b1;
            end else if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
            end
        end
    end

`ifdef CMD_CHECKSUM_EN
    // XOR over data plus checksum byte is zero exactly when the checksum matches.
    logic [7:0] xor_acc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xor_acc <= '0;
            chk_err <= 1'b0;
        end else begin
            chk_err <= (state == CHECK) && chk_bad;
            if (take) xor_acc <= (byte_cnt == '0) ? in_byte : (xor_acc ^ in_byte);
        end
    end

    assign chk_bad = (xor_acc != 8'h00);
`else
    assign chk_bad = 1'b0;
`endif

endmodule
